qsfp_xcvr_test_csr_agent: RTL and testbench
===========================================

# qsfp_xcvr_test_csr_agent

Avalon-MM responder (agent) terminating the m0 side of the transceiver-test MM bridge. Decodes a fixed 8-word CSR map with byte-enabled writes, programmable wait states on command acceptance and fixed-latency pipelined read responses. Drives transceiver-test control and samples status. It is the register target the bridge's master port talks to.

## Interface
- ADDR_WIDTH, 15: word address width; only bits [2:0] decode, upper bits must be zero for a hit.
- WAIT_STATES, 0: cycles waitrequest is held high before each command is accepted (0..7).
- READ_LATENCY, 2: accept-to-readdatavalid cycles (1..4).
- ID_VALUE, 32'h5153_0001: constant returned by register 0.

- clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- s0_waitrequest  out  1  command not accepted this cycle.
- s0_readdata  out  32  read response data.
- s0_readdatavalid  out  1  s0_readdata valid this cycle.
- s0_burstcount  in  1  must be 1; other values are treated as 1.
- s0_writedata  in  32  write data.
- s0_address  in  ADDR_WIDTH  word address.
- s0_write  in  1  write command.
- s0_read  in  1  read command.
- s0_byteenable  in  4  per-byte write enable; ignored on reads.
- s0_debugaccess  in  1  permits writes to read-only COUNTER.
- ctrl_out  out  32  CTRL register contents.
- status_in  in  32  transceiver status, sampled every cycle.

## Operation
- Map: 0 ID (RO), 1 SCRATCH (RW), 2 CTRL (RW, drives ctrl_out), 3 STATUS (RO, status_in registered one cycle), 4 COUNTER (RO, free-running +1 per clk, wraps at 2^32), 5 WRCOUNT (RO, count of accepted writes, wraps), 6-7 and any address with nonzero upper bits: reads return 32'h0, writes are ignored but still counted.
- Accept = (s0_read|s0_write) & ~s0_waitrequest.
- Writes update only the enabled bytes. Writes to RO registers are ignored, except COUNTER when s0_debugaccess=1: enabled bytes are loaded and counting resumes from the loaded value.
- Read data is captured at the acceptance cycle and shifts through a READ_LATENCY-deep valid/data pipeline. No response backpressure.
- read & write asserted together: the write executes, the read is dropped, no readdatavalid.
- Wait FSM (WAIT_STATES>0): IDLE -> WAIT when a command is present. WAIT counts WAIT_STATES cycles -> ACCEPT. ACCEPT drops waitrequest for one cycle -> IDLE.
- If the command drops during WAIT (protocol violation), the FSM returns to IDLE and the count clears.
- WAIT_STATES=0: waitrequest is low whenever out of reset; a command is accepted every cycle.

## Timing
- Reset values: s0_waitrequest=1, s0_readdatavalid=0, s0_readdata=0, ctrl_out=0. SCRATCH, CTRL, COUNTER, WRCOUNT and the STATUS sample are all 0.
- s0_waitrequest goes low the first cycle after reset_n rises (WAIT_STATES=0). With WAIT_STATES>0 it stays high until the ACCEPT state.
- Write accepted at T: register visible to a read accepted at T+1; ctrl_out updates at T+1.
- Read accepted at T: readdatavalid at T+READ_LATENCY. Data is the register value at T (before any write in the same cycle).
- Back-to-back reads give back-to-back valids, in order.
- COUNTER read at T returns the value held at T.
- reset_n low mid-operation: pending responses are discarded (no valid) and the FSM returns to IDLE.

## Configuration
- QSFP_CSR_AGENT_COUNTER_EN defined: COUNTER register implemented as above.
- Not defined: register 4 reads 0, writes (including debugaccess) are ignored, and no counter logic is built.

## Test plan
- Reset, then read addr 0, WAIT_STATES=0, READ_LATENCY=2 -> accepted in the first cycle out of reset; readdatavalid 2 cycles later with 32'h5153_0001.
- Write SCRATCH 32'hFFFF_FFFF, then write 32'h1234_5678 with be=4'b0101, then read -> 32'hFF34_FF78. WRCOUNT reads 2.
- WAIT_STATES=3, single write to CTRL 32'hA5 -> waitrequest high 4 cycles, low 1; ctrl_out=32'hA5 the cycle after acceptance.
- Four back-to-back reads (addr 0,1,2,7), READ_LATENCY=4 -> four consecutive valids in order; addr 7 returns 0.
- Write COUNTER 32'h100 with debugaccess=0 -> ignored. With debugaccess=1 -> a read accepted 5 cycles later returns 32'h104 (macro defined) or 0 (undefined).
- Read and write to SCRATCH asserted together -> the write lands, no readdatavalid. Reset asserted with 2 reads in flight -> no valids after reset.

Source files
------------

// File: rtl/qsfp_xcvr_test_csr_agent.sv
// Avalon-MM CSR agent on the m0 side of the transceiver-test bridge: 8-word map, wait states, pipelined reads.
// Define QSFP_CSR_AGENT_COUNTER_EN to build the free-running COUNTER register at word 4.
module qsfp_xcvr_test_csr_agent #(
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [31:0] ID_VALUE     = 32'h5153_0001
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  s0_waitrequest,
    output logic [31:0]           s0_readdata,
    output logic                  s0_readdatavalid,
    input  logic                  s0_burstcount,
    input  logic [31:0]           s0_writedata,
    input  logic [ADDR_WIDTH-1:0] s0_address,
    input  logic                  s0_write,
    input  logic                  s0_read,
    input  logic [3:0]            s0_byteenable,
    input  logic                  s0_debugaccess,
    output logic [31:0]           ctrl_out,
    input  logic [31:0]           status_in
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCEPT
    } waitState_e;

    logic        cmdPresent;
    logic        accept;
    logic        isWrite;
    logic        isRead;
    logic        addrHit;
    logic [2:0]  regSel;
    logic        waitReq_q;

    logic [31:0] scratch_q, scratch_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] wrCount_q, wrCount_d;
    logic [31:0] status_q;
    logic [31:0] counterVal;
    logic [31:0] readMux;

    logic [READ_LATENCY-1:0] pipeValid_q;
    logic [31:0]             pipeData_q [READ_LATENCY];

    // Bursts are always single-beat here, so the burst count carries no information.
    logic unusedBurst;
    assign unusedBurst = s0_burstcount;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  be);
        mergeBytes = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mergeBytes[8*b +: 8] = newVal[8*b +: 8];
        end
    endfunction

    assign cmdPresent     = s0_read | s0_write;
    assign accept         = cmdPresent & ~s0_waitrequest;
    assign isWrite        = accept & s0_write;
    assign isRead         = accept & s0_read & ~s0_write;
    assign addrHit        = (s0_address[ADDR_WIDTH-1:3] == '0);
    assign regSel         = s0_address[2:0];
    assign s0_waitrequest = waitReq_q;

    generate
        if (WAIT_STATES == 0) begin : g_noWait
            always_ff @(posedge clk) begin
                if (!reset_n) waitReq_q <= 1'b1;
                else          waitReq_q <= 1'b0;
            end
        end else begin : g_waitFsm
            localparam int unsigned CW = $clog2(WAIT_STATES + 1);
            waitState_e    state_q;
            logic [CW-1:0] waitCnt_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    state_q   <= ST_IDLE;
                    waitCnt_q <= '0;
                    waitReq_q <= 1'b1;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (cmdPresent) begin
                                state_q   <= ST_WAIT;
                                waitCnt_q <= '0;
                            end
                        end
                        ST_WAIT: begin
                            if (!cmdPresent) begin
                                state_q   <= ST_IDLE;
                                waitCnt_q <= '0;
                            end else if (waitCnt_q == CW'(WAIT_STATES - 1)) begin
                                state_q   <= ST_ACCEPT;
                                waitCnt_q <= '0;
                                waitReq_q <= 1'b0;
                            end else begin
                                waitCnt_q <= waitCnt_q + 1'b1;
                            end
                        end
                        ST_ACCEPT: begin
                            state_q   <= ST_IDLE;
                            waitReq_q <= 1'b1;
                        end
                        default: begin
                            state_q   <= ST_IDLE;
                            waitCnt_q <= '0;
                            waitReq_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Every accepted write is counted, even when it lands on a read-only or unmapped word.
    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        wrCount_d = wrCount_q;
        if (isWrite) begin
            wrCount_d = wrCount_q + 32'd1;
            if (addrHit && regSel == 3'd1) scratch_d = mergeBytes(scratch_q, s0_writedata, s0_byteenable);
            if (addrHit && regSel == 3'd2) ctrl_d    = mergeBytes(ctrl_q, s0_writedata, s0_byteenable);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            wrCount_q <= '0;
            status_q  <= '0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            wrCount_q <= wrCount_d;
            status_q  <= status_in;
        end
    end

`ifdef QSFP_CSR_AGENT_COUNTER_EN
    logic [31:0] counter_q, counter_d;

    always_comb begin
        counter_d = counter_q + 32'd1;
        if (isWrite && addrHit && regSel == 3'd4 && s0_debugaccess)
            counter_d = mergeBytes(counter_q, s0_writedata, s0_byteenable);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) counter_q <= '0;
        else          counter_q <= counter_d;
    end

    assign counterVal = counter_q;
`else
    logic unusedDebug;
    assign unusedDebug = s0_debugaccess;
    assign counterVal  = '0;
`endif

    always_comb begin
        readMux = '0;
        if (addrHit) begin
            case (regSel)
                3'd0:    readMux = ID_VALUE;
                3'd1:    readMux = scratch_q;
                3'd2:    readMux = ctrl_q;
                3'd3:    readMux = status_q;
                3'd4:    readMux = counterVal;
                3'd5:    readMux = wrCount_q;
                default: readMux = '0;
            endcase
        end
    end

    // Read data is frozen at acceptance so a same-cycle write never leaks into the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipeValid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipeData_q[i] <= '0;
        end else begin
            pipeValid_q[0] <= isRead;
            pipeData_q[0]  <= readMux;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeData_q[i]  <= pipeData_q[i-1];
            end
        end
    end

    assign s0_readdatavalid = pipeValid_q[READ_LATENCY-1];
    assign s0_readdata      = pipeData_q[READ_LATENCY-1];
    assign ctrl_out         = ctrl_q;

endmodule

// File: tb/tb_qsfp_xcvr_test_csr_agent.sv
// Directed bench for qsfp_xcvr_test_csr_agent: three instances (no-wait/latency 2, no-wait/latency 4, 3 wait states).
// Expected COUNTER value follows QSFP_CSR_AGENT_COUNTER_EN.
module tb_qsfp_xcvr_test_csr_agent;

    localparam logic [31:0] ID = 32'h5153_0001;

    logic        clk;
    logic        reset_n;
    logic        s0Read;
    logic        s0Write;
    logic [14:0] s0Address;
    logic [31:0] s0WriteData;
    logic [3:0]  s0ByteEnable;
    logic        s0DebugAccess;
    logic        s0BurstCount;
    logic [31:0] statusIn;

    logic        aWait, aValid, bWait, bValid, cWait, cValid;
    logic [31:0] aData, aCtrl, bData, bCtrl, cData, cCtrl;

    int total = 0;
    int bad   = 0;

    logic [14:0] rdAddr [4] = '{15'd0, 15'd1, 15'd2, 15'd7};
    logic [31:0] rdExp  [4] = '{32'h5153_0001, 32'hFF34_FF78, 32'h0000_00C3, 32'h0};
    logic [31:0] counterExp;

    qsfp_xcvr_test_csr_agent #(.ADDR_WIDTH(15), .WAIT_STATES(0), .READ_LATENCY(2), .ID_VALUE(ID)) dutA (
        .clk(clk), .reset_n(reset_n),
        .s0_waitrequest(aWait), .s0_readdata(aData), .s0_readdatavalid(aValid),
        .s0_burstcount(s0BurstCount), .s0_writedata(s0WriteData), .s0_address(s0Address),
        .s0_write(s0Write), .s0_read(s0Read), .s0_byteenable(s0ByteEnable),
        .s0_debugaccess(s0DebugAccess), .ctrl_out(aCtrl), .status_in(statusIn)
    );

    qsfp_xcvr_test_csr_agent #(.ADDR_WIDTH(15), .WAIT_STATES(0), .READ_LATENCY(4), .ID_VALUE(ID)) dutB (
        .clk(clk), .reset_n(reset_n),
        .s0_waitrequest(bWait), .s0_readdata(bData), .s0_readdatavalid(bValid),
        .s0_burstcount(s0BurstCount), .s0_writedata(s0WriteData), .s0_address(s0Address),
        .s0_write(s0Write), .s0_read(s0Read), .s0_byteenable(s0ByteEnable),
        .s0_debugaccess(s0DebugAccess), .ctrl_out(bCtrl), .status_in(statusIn)
    );

    qsfp_xcvr_test_csr_agent #(.ADDR_WIDTH(15), .WAIT_STATES(3), .READ_LATENCY(2), .ID_VALUE(ID)) dutC (
        .clk(clk), .reset_n(reset_n),
        .s0_waitrequest(cWait), .s0_readdata(cData), .s0_readdatavalid(cValid),
        .s0_burstcount(s0BurstCount), .s0_writedata(s0WriteData), .s0_address(s0Address),
        .s0_write(s0Write), .s0_read(s0Read), .s0_byteenable(s0ByteEnable),
        .s0_debugaccess(s0DebugAccess), .ctrl_out(cCtrl), .status_in(statusIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rd, input logic wr, input logic [14:0] addr,
                                 input logic [31:0] data, input logic [3:0] be, input logic dbg);
        s0Read        = rd;
        s0Write       = wr;
        s0Address     = addr;
        s0WriteData   = data;
        s0ByteEnable  = be;
        s0DebugAccess = dbg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
`ifdef QSFP_CSR_AGENT_COUNTER_EN
        counterExp = 32'h0000_0104;
`else
        counterExp = 32'h0;
`endif
        s0BurstCount = 1'b1;
        statusIn     = 32'h0;
        reset_n      = 1'b0;
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        repeat (3) step();

        checkOutput("rst_wait", {31'd0, aWait}, 32'd1);
        checkOutput("rst_valid", {31'd0, aValid}, 32'd0);
        checkOutput("rst_data", aData, 32'h0);
        checkOutput("rst_ctrl", aCtrl, 32'h0);
        checkOutput("rst_wait_c", {31'd0, cWait}, 32'd1);

        reset_n = 1'b1;
        step();
        checkOutput("wait_low", {31'd0, aWait}, 32'd0);

        // ID read accepted first cycle out of reset
        applyStimulus(1'b1, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        checkOutput("id_valid_early", {31'd0, aValid}, 32'd0);
        step();
        checkOutput("id_valid", {31'd0, aValid}, 32'd1);
        checkOutput("id_data", aData, ID);
        step();
        checkOutput("id_valid_once", {31'd0, aValid}, 32'd0);
        step();
        checkOutput("id_valid_lat4", {31'd0, bValid}, 32'd1);
        checkOutput("id_data_lat4", bData, ID);

        // Byte-enabled SCRATCH writes, then SCRATCH and WRCOUNT reads
        applyStimulus(1'b0, 1'b1, 15'd1, 32'hFFFF_FFFF, 4'hF, 1'b0);
        step();
        applyStimulus(1'b0, 1'b1, 15'd1, 32'h1234_5678, 4'b0101, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 15'd1, 32'h0, 4'h0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 15'd5, 32'h0, 4'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        checkOutput("scratch_valid", {31'd0, aValid}, 32'd1);
        checkOutput("scratch_data", aData, 32'hFF34_FF78);
        step();
        checkOutput("wrcount_valid", {31'd0, aValid}, 32'd1);
        checkOutput("wrcount_data", aData, 32'd2);

        // STATUS is a one-cycle-old sample of status_in
        statusIn = 32'hDEAD_BEEF;
        step();
        applyStimulus(1'b1, 1'b0, 15'd3, 32'h0, 4'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        step();
        checkOutput("status_data", aData, 32'hDEAD_BEEF);
        checkOutput("status_valid", {31'd0, aValid}, 32'd1);

        applyStimulus(1'b0, 1'b1, 15'd2, 32'h0000_00C3, 4'hF, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        checkOutput("ctrl_out", aCtrl, 32'h0000_00C3);

        // Four back-to-back reads on the latency-4 instance
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, rdAddr[i], 32'h0, 4'h0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("b2b_valid%0d", i), {31'd0, bValid}, 32'd1);
            checkOutput($sformatf("b2b_data%0d", i), bData, rdExp[i]);
            step();
        end
        checkOutput("b2b_valid_end", {31'd0, bValid}, 32'd0);

        // COUNTER: debug write loads it, plain write is ignored
        applyStimulus(1'b0, 1'b1, 15'd4, 32'h0000_0100, 4'hF, 1'b1);
        step();
        applyStimulus(1'b0, 1'b1, 15'd4, 32'h0, 4'hF, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        repeat (3) step();
        applyStimulus(1'b1, 1'b0, 15'd4, 32'h0, 4'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        step();
        checkOutput("counter_valid", {31'd0, aValid}, 32'd1);
        checkOutput("counter_data", aData, counterExp);

        // Read and write together: write lands, read dropped
        applyStimulus(1'b1, 1'b1, 15'd1, 32'hCAFE_F00D, 4'hF, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 15'd1, 32'h0, 4'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        checkOutput("rw_read_dropped", {31'd0, aValid}, 32'd0);
        step();
        checkOutput("rw_write_valid", {31'd0, aValid}, 32'd1);
        checkOutput("rw_write_data", aData, 32'hCAFE_F00D);

        // Reset with reads in flight
        applyStimulus(1'b1, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        step();
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        reset_n = 1'b0;
        step();
        checkOutput("rst_flight_valid_a", {31'd0, aValid}, 32'd0);
        checkOutput("rst_flight_wait", {31'd0, aWait}, 32'd1);
        step();
        checkOutput("rst_flight_valid_b0", {31'd0, bValid}, 32'd0);
        reset_n = 1'b1;
        step();
        checkOutput("rst_flight_valid_b1", {31'd0, bValid}, 32'd0);

        // Three wait states: waitrequest high 4 cycles, then low 1
        applyStimulus(1'b0, 1'b1, 15'd2, 32'h0000_00A5, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ws_wait_hi%0d", i), {31'd0, cWait}, 32'd1);
            step();
        end
        checkOutput("ws_wait_lo", {31'd0, cWait}, 32'd0);
        checkOutput("ws_ctrl_before", cCtrl, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 15'd0, 32'h0, 4'h0, 1'b0);
        checkOutput("ws_ctrl_after", cCtrl, 32'h0000_00A5);
        checkOutput("ws_wait_back_hi", {31'd0, cWait}, 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
